centroid_ctrl: RTL and testbench

CENTROID_CTRL -- requirements
Module: centroid_ctrl

---
 rtl/centroid_pkg.sv | 24 ++
 rtl/centroid_edge_det.sv | 21 ++
 rtl/centroid_ctrl.sv | 151 +++++++++++++++
 tb/tb_centroid_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/centroid_pkg.sv
// Shared types and widths for the centroid tracking controller.
package centroid_pkg;

  localparam int COORD_W = 10;
  localparam int CNT_W   = 13;
  localparam int FCNT_W  = 16;

  // Frame sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_LATCH = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

  // Rounded mean of two coordinates; the sum needs one extra bit
  function automatic logic [COORD_W-1:0] avg_round(input logic [COORD_W-1:0] a,
                                                   input logic [COORD_W-1:0] b);
    logic [COORD_W:0] s;
    s = {1'b0, a} + {1'b0, b} + (COORD_W+1)'(1);
    return s[COORD_W:1];
  endfunction

endpackage

// File: rtl/centroid_edge_det.sv
// Rising-edge detector on a registered copy of the input.
// rise is high in the cycle where sig is 1 and its registered copy is still 0.
module centroid_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  // Registered copy of sig; holds while ce is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     sig_q <= 1'b0;
    else if (ce) sig_q <= sig;
  end

  assign rise = ce & sig & ~sig_q;

endmodule

// File: rtl/centroid_ctrl.sv
// Frame controller for the skin-colour centroid tracker.
// Counts pixels and mask hits per frame, latches the centroid at frame end,
// clears the circle datapath once per frame and tracks target loss.
// Optional macro CENTROID_SMOOTH_EN: detections are averaged with the
// previous position instead of loaded directly.
//
// Handshake note: there is no valid/ready pair; the frame-end event is the
// vsync rising edge, and the latched outputs are stable two cycles after it.
module centroid_ctrl
  import centroid_pkg::*;
#(
  parameter int IMG_W       = 64,
  parameter int IMG_H       = 64,
  parameter int MIN_PIX     = 16,
  parameter int LOST_FRAMES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic               de,
  input  logic               hsync,
  input  logic               vsync,
  input  logic               mask,
  input  logic [COORD_W-1:0] x_in,
  input  logic [COORD_W-1:0] y_in,
  output logic               circ_ce,
  output logic               circ_rst,
  output logic [COORD_W-1:0] x_out,
  output logic [COORD_W-1:0] y_out,
  output logic               track_valid,
  output logic               overlay_en,
  output logic               frame_err,
  output logic [FCNT_W-1:0]  frame_cnt,
  output state_t             state_dbg
);

  localparam int MISS_W = $clog2(LOST_FRAMES + 1);
  localparam logic [CNT_W-1:0]  FRAME_PIX = CNT_W'(IMG_W * IMG_H);
  localparam logic [CNT_W-1:0]  MIN_CNT   = CNT_W'(MIN_PIX);
  localparam logic [MISS_W-1:0] LOST_CNT  = MISS_W'(LOST_FRAMES);

  state_t             state, state_nxt;
  logic               vs_rise;
  logic               count_en, latch_en, clear_en;
  logic [CNT_W-1:0]   pix_cnt, msk_cnt;
  logic [MISS_W-1:0]  miss_cnt, miss_inc;
  logic               pix_ok, detect;
  logic [COORD_W-1:0] x_nxt, y_nxt;

  // Line timing is not needed: pixels are counted from de alone
  logic unused_hsync;
  assign unused_hsync = hsync;

  centroid_edge_det u_vs_edge (
    .clk  (clk),
    .rst  (rst),
    .ce   (ce),
    .sig  (vsync),
    .rise (vs_rise)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     state <= ST_IDLE;
    else if (ce) state <= state_nxt;
  end

  // Next-state logic; edges seen in LATCH/CLEAR are ignored
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (vs_rise) state_nxt = ST_RUN;
      ST_RUN:   if (vs_rise) state_nxt = ST_LATCH;
      ST_LATCH: state_nxt = ST_CLEAR;
      ST_CLEAR: state_nxt = ST_RUN;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded outputs; the datapath is held clear until the first frame starts
  always_comb begin
    circ_rst = 1'b0;
    circ_ce  = 1'b0;
    count_en = 1'b0;
    latch_en = 1'b0;
    clear_en = 1'b0;
    case (state)
      ST_IDLE:  circ_rst = 1'b1;
      ST_RUN:   begin circ_ce = ce; count_en = ce; end
      ST_LATCH: begin circ_ce = ce; latch_en = ce; end
      ST_CLEAR: begin circ_ce = ce; clear_en = ce; circ_rst = 1'b1; end
      default:  circ_rst = 1'b1;
    endcase
  end

  assign state_dbg  = state;
  assign overlay_en = track_valid & ce;

  // Saturating per-frame pixel and mask counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt <= '0;
      msk_cnt <= '0;
    end else if (clear_en) begin
      pix_cnt <= '0;
      msk_cnt <= '0;
    end else if (count_en) begin
      if (de && (pix_cnt != '1))         pix_cnt <= pix_cnt + CNT_W'(1);
      if (de && mask && (msk_cnt != '1)) msk_cnt <= msk_cnt + CNT_W'(1);
    end
  end

  // Frame-end decision and next coordinates
  always_comb begin
    pix_ok   = (pix_cnt == FRAME_PIX);
    detect   = pix_ok && (msk_cnt >= MIN_CNT);
    miss_inc = (miss_cnt >= LOST_CNT) ? miss_cnt : miss_cnt + MISS_W'(1);
`ifdef CENTROID_SMOOTH_EN
    x_nxt = track_valid ? avg_round(x_out, x_in) : x_in;
    y_nxt = track_valid ? avg_round(y_out, y_in) : y_in;
`else
    x_nxt = x_in;
    y_nxt = y_in;
`endif
  end

  // Result registers, updated only in LATCH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_out       <= '0;
      y_out       <= '0;
      track_valid <= 1'b0;
      frame_err   <= 1'b0;
      frame_cnt   <= '0;
      miss_cnt    <= '0;
    end else if (latch_en) begin
      frame_err <= ~pix_ok;
      frame_cnt <= frame_cnt + FCNT_W'(1);
      if (detect) begin
        x_out       <= x_nxt;
        y_out       <= y_nxt;
        track_valid <= 1'b1;
        miss_cnt    <= '0;
      end else begin
        miss_cnt <= miss_inc;
        if (miss_inc >= LOST_CNT) track_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_centroid_ctrl.sv
// Directed bench for centroid_ctrl: whole frames are driven, the expected
// outputs for each vsync edge are queued, and a monitor checks them.
module tb_centroid_ctrl;
  import centroid_pkg::*;

  localparam int IMG_W = 64;
  localparam int IMG_H = 64;

  logic               rx_pclk;
  logic               rst, ce, de, hsync, vsync, mask;
  logic [COORD_W-1:0] x_in, y_in;
  logic               circ_ce, circ_rst, track_valid, overlay_en, frame_err;
  logic [COORD_W-1:0] x_out, y_out;
  logic [FCNT_W-1:0]  frame_cnt;
  state_t             state_dbg;

  // {latch, x[37:28], y[27:18], tv[17], ferr[16], fcnt[15:0]}
  logic [38:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  centroid_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .MIN_PIX(16), .LOST_FRAMES(4)) dut (
    .clk(rx_pclk), .rst(rst), .ce(ce), .de(de), .hsync(hsync), .vsync(vsync),
    .mask(mask), .x_in(x_in), .y_in(y_in), .circ_ce(circ_ce), .circ_rst(circ_rst),
    .x_out(x_out), .y_out(y_out), .track_valid(track_valid), .overlay_en(overlay_en),
    .frame_err(frame_err), .frame_cnt(frame_cnt), .state_dbg(state_dbg)
  );

  // Clock
  initial rx_pclk = 1'b0;
  always #5 rx_pclk = ~rx_pclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge rx_pclk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_x"},        32'(x_out), 0);
    check({tag, "_y"},        32'(y_out), 0);
    check({tag, "_tv"},       32'(track_valid), 0);
    check({tag, "_ferr"},     32'(frame_err), 0);
    check({tag, "_fcnt"},     32'(frame_cnt), 0);
    check({tag, "_circ_rst"}, 32'(circ_rst), 1);
    check({tag, "_circ_ce"},  32'(circ_ce), 0);
    check({tag, "_overlay"},  32'(overlay_en), 0);
    check({tag, "_state"},    32'(state_dbg), 32'(ST_IDLE));
  endtask

  // Drive 'lines' lines of IMG_W pixels; first n_mask pixels are mask hits.
  // mask is also high in blanking, where de=0 must make it irrelevant.
  // On stall_line a 3-cycle ce=0 gap is inserted with de=1.
  task automatic drive_frame(input int lines, input int n_mask, input int stall_line);
    int idx;
    idx = 0;
    for (int l = 0; l < lines; l++) begin
      for (int p = 0; p < IMG_W; p++) begin
        if (l == stall_line && p == 5) begin
          for (int s = 0; s < 3; s++) begin
            step();
            ce = 1'b0; de = 1'b1; mask = 1'b1;
            @(negedge rx_pclk);
            check("stall_circ_ce", 32'(circ_ce), 0);
            check("stall_overlay", 32'(overlay_en), 0);
          end
        end
        step();
        ce = 1'b1; de = 1'b1; hsync = 1'b0; mask = (idx < n_mask);
        idx++;
      end
      step();
      de = 1'b0; hsync = 1'b1; mask = 1'b1;
    end
    step();
    hsync = 1'b0; mask = 1'b0;
  endtask

  // Present the centroid, queue the expected result and pulse vsync
  task automatic frame_end(input int xi, input int yi, input logic latch,
                           input int ex, input int ey, input logic etv,
                           input logic eferr, input int efcnt);
    step();
    de = 1'b0; x_in = xi[9:0]; y_in = yi[9:0];
    exp_q.push_back({latch, ex[9:0], ey[9:0], etv, eferr, efcnt[15:0]});
    step();
    vsync = 1'b1;
    repeat (3) step();
    vsync = 1'b0;
    repeat (3) step();
  endtask

  // Monitor: on each vsync rising edge, outputs hold one cycle, update the next
  initial begin
    logic [38:0] e, prev;
    logic        vs_prev;
    prev = '0;
    vs_prev = 1'b0;
    forever begin
      @(negedge rx_pclk);
      if (rst) begin
        prev = '0;
      end else if (vsync && !vs_prev) begin
        @(negedge rx_pclk);
        check("hold_fcnt", 32'(frame_cnt), 32'(prev[15:0]));
        check("hold_x", 32'(x_out), 32'(prev[37:28]));
        check("edge1_circ_rst", 32'(circ_rst), 0);
        @(negedge rx_pclk);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL scoreboard: frame end with empty expected queue");
        end else begin
          e = exp_q.pop_front();
          check("x_out", 32'(x_out), 32'(e[37:28]));
          check("y_out", 32'(y_out), 32'(e[27:18]));
          check("track_valid", 32'(track_valid), 32'(e[17]));
          check("overlay_en", 32'(overlay_en), 32'(e[17]));
          check("frame_err", 32'(frame_err), 32'(e[16]));
          check("frame_cnt", 32'(frame_cnt), 32'(e[15:0]));
          check("clear_circ_rst", 32'(circ_rst), 32'(e[38]));
          prev = e;
        end
        @(negedge rx_pclk);
        check("run_circ_rst", 32'(circ_rst), 0);
        check("run_circ_ce", 32'(circ_ce), 1);
      end
      vs_prev = vsync;
    end
  end

  // Watchdog
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    rst = 1'b1; ce = 1'b1; de = 1'b0; hsync = 1'b0; vsync = 1'b0; mask = 1'b0;
    x_in = '0; y_in = '0;
    repeat (3) step();
    rst = 1'b0;
    @(negedge rx_pclk);
    check_reset_vals("por");
    repeat (2) step();

    // First edge leaves IDLE without latching
    frame_end(0, 0, 1'b0, 0, 0, 1'b0, 1'b0, 0);
    // Three detecting frames (one with a ce stall)
    drive_frame(IMG_H, 100, -1); frame_end(20, 30, 1'b1, 20, 30, 1'b1, 1'b0, 1);
    drive_frame(IMG_H, 100, 10); frame_end(20, 30, 1'b1, 20, 30, 1'b1, 1'b0, 2);
    drive_frame(IMG_H, 100, -1); frame_end(20, 30, 1'b1, 20, 30, 1'b1, 1'b0, 3);
    // Detection with new coordinates
    drive_frame(IMG_H, 100, -1);
`ifdef CENTROID_SMOOTH_EN
    frame_end(31, 41, 1'b1, 26, 36, 1'b1, 1'b0, 4);
`else
    frame_end(31, 41, 1'b1, 31, 41, 1'b1, 1'b0, 4);
`endif
    // Five low-mask frames: track drops after the fourth
    for (int f = 0; f < 5; f++) begin
      drive_frame(IMG_H, 5, -1);
`ifdef CENTROID_SMOOTH_EN
      frame_end(50, 60, 1'b1, 26, 36, (f < 3), 1'b0, 5 + f);
`else
      frame_end(50, 60, 1'b1, 31, 41, (f < 3), 1'b0, 5 + f);
`endif
    end
    // Short frame: error, no update
    drive_frame(IMG_H - 1, 100, -1);
`ifdef CENTROID_SMOOTH_EN
    frame_end(40, 45, 1'b1, 26, 36, 1'b0, 1'b1, 10);
`else
    frame_end(40, 45, 1'b1, 31, 41, 1'b0, 1'b1, 10);
`endif
    // Correct frame reacquires with a direct load
    drive_frame(IMG_H, 100, -1); frame_end(22, 32, 1'b1, 22, 32, 1'b1, 1'b0, 11);

    // Reset in the middle of a frame
    drive_frame(10, 100, -1);
    step();
    rst = 1'b1;
    @(negedge rx_pclk);
    check_reset_vals("mid_rst");
    repeat (2) step();
    rst = 1'b0;
    @(negedge rx_pclk);
    check_reset_vals("post_rst");
    frame_end(9, 9, 1'b0, 0, 0, 1'b0, 1'b0, 0);
    drive_frame(IMG_H, 100, -1); frame_end(7, 9, 1'b1, 7, 9, 1'b1, 1'b0, 1);

    repeat (10) step();
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
